hamming_dec_engine: RTL and testbench
=====================================

# hamming_dec_engine

Memory-mapped SECDED Hamming decoder, the receive-side counterpart of the program-1 parity encoder. On a start pulse it reads N_MSG 16-bit codewords (two bytes each) from data memory. For each codeword it corrects any single-bit error, flags double-bit errors, and writes the 11-bit payload plus a 2-bit error flag back to memory. It sits beside the data memory (`dm1`) in `top_level` and shares the memory port during its run.

## Interface
- `SRC_BASE`, default 30: byte address of the first codeword's low byte.
- `DST_BASE`, default 0: byte address of the first result's low byte.
- `N_MSG`, default 15: number of codewords to decode, range 1..127.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high; returns the block to IDLE.
- `start` input, 1 bit: one-cycle request; sampled only in IDLE.
- `done` output, 1 bit: level; high in DONE state.
- `mem_addr` output, 8 bits: byte address to data memory.
- `mem_rd_data` input, 8 bits: combinational read data for `mem_addr`.
- `mem_we` output, 1 bit: write enable; the memory writes on the rising edge.
- `mem_wr_data` output, 8 bits: write data.
- `err1_cnt` output, 8 bits: count of corrected single errors in the current or last run.
- `err2_cnt` output, 8 bits: count of detected double errors in the current or last run.

## Operation
- Codeword layout, bit 15 down to bit 0: {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}.
  - Codeword bits [15:1] are Hamming positions 15..1.
  - Bit 0 is overall parity.
- Syndrome bits:
  - s8 = ^cw[15:8].
  - s4 = ^{cw[15:12], cw[7:4]}.
  - s2 = ^{cw[15:14], cw[11:10], cw[7:6], cw[3:2]}.
  - s1 = ^{all odd-indexed bits 15..1}.
  - P = ^cw[15:0].
- Error classification:
  - s=0, P=0: no error, F=2'b00.
  - P=1: single error. If s≠0, flip position s; if s=0, only p0 was hit and data is unchanged. F=2'b01, increment err1_cnt.
  - s≠0, P=0: double error. Data is extracted uncorrected. F=2'b10, increment err2_cnt.
- Result for message i:
  - byte DST_BASE+2i+1 = {F[1], F[0], 3'b000, d11, d10, d9}.
  - byte DST_BASE+2i = d8..d1.
- Codeword i is read from bytes SRC_BASE+2i (low) and SRC_BASE+2i+1 (high).
- FSM states: IDLE → RD_LO → RD_HI → WR_LO → WR_HI → (RD_LO, or DONE after the last message).
  - IDLE: start=1 clears the message index and both counters, then goes to RD_LO.
  - RD_LO: drives the low address and latches `mem_rd_data` into lo_reg.
  - RD_HI: drives the high address. Decodes {mem_rd_data, lo_reg} and registers the result bytes and flag.
  - WR_LO: mem_we=1, writes the low result byte.
  - WR_HI: mem_we=1, writes the high result byte, updates counters, increments the index.
  - DONE: holds `done` high. start=1 restarts exactly as from IDLE (same cycle semantics). Otherwise stays in DONE.
- Outside WR states, mem_we is 0. `start` is ignored in any state other than IDLE and DONE.
- Address arithmetic is 8-bit and wraps modulo 256; no range check.

## Timing
- Reset values: done=0, mem_we=0, mem_addr=0, mem_wr_data=0, err1_cnt=0, err2_cnt=0, state=IDLE, index=0.
- start is sampled high at edge T. Message 0 then occupies cycles T+1..T+4; message i occupies T+1+4i .. T+4+4i.
- `done` rises at edge T+1+4·N_MSG: cycle 61 for N_MSG=15.
- Each result byte is written on the edge that ends its WR cycle.
- Counters are valid once done=1 and hold until the next start.
- Reset during a run aborts it immediately on the next edge:
  - Completed writes remain in memory.
  - The write in progress in that cycle is suppressed; reset has priority over mem_we.
- Simultaneous reset and start: reset wins, and the block stays in IDLE.

## Structure
- Shared package `hamming_pkg`, containing:
  - State enum.
  - Flag constants: FLAG_NONE, FLAG_SINGLE, FLAG_DOUBLE.
  - Bit-position constants for the codeword layout.
  - Syndrome/parity function, also reused by the encoder.
- Sub-module `hamming_secded_dec`: combinational.
  - Input: 16-bit codeword.
  - Outputs: 11-bit data, 2-bit flag.
- The engine contains only the FSM, address and index counters, registers, and error counters.

## Test plan
- Clean codeword 0xAA5A (data 11'b10101010101) at bytes 30/31 → bytes 0/1 = 0x55/0x05; err1=0, err2=0.
- Data bit flip at position 9, codeword 0xA85A → bytes 0/1 = 0x55/0x45; err1=1.
- Overall-parity-only flip, codeword 0xAA5B → bytes 0/1 = 0x55/0x45; err1=1.
- Double flip at positions 9 and 3, codeword 0xA852 → bytes 0/1 = 0x44/0x85; err2=1.
- Full run of 15 random codewords with a mix of 0/1/2 flips → every result matches the reference model; done rises exactly 61 cycles after start; counters match the injected error counts.
- reset asserted during WR_LO of message 3 → messages 0–2 written, message 3 bytes untouched, done=0, counters=0; a following start completes normally.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming definitions: FSM states, flag codes, codeword layout
// and the syndrome/parity helper used by both the encoder and the decoder.
package hamming_pkg;

   // Engine sequencing states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_LO = 3'd1,
      ST_RD_HI = 3'd2,
      ST_WR_LO = 3'd3,
      ST_WR_HI = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // Two-bit error classification written into the result high byte
   localparam logic [1:0] FLAG_NONE   = 2'b00;
   localparam logic [1:0] FLAG_SINGLE = 2'b01;
   localparam logic [1:0] FLAG_DOUBLE = 2'b10;

   // Check-bit positions inside the 16-bit codeword (bit 0 = overall parity)
   localparam int POS_P0 = 0;
   localparam int POS_P1 = 1;
   localparam int POS_P2 = 2;
   localparam int POS_P4 = 4;
   localparam int POS_P8 = 8;

   // Positions covered by each syndrome bit (Hamming positions whose index has that bit set)
   localparam logic [15:0] MASK_S8 = 16'hFF00;
   localparam logic [15:0] MASK_S4 = 16'hF0F0;
   localparam logic [15:0] MASK_S2 = 16'hCCCC;
   localparam logic [15:0] MASK_S1 = 16'hAAAA;

   // Returns {overall parity, s8, s4, s2, s1}; s[3:0] is the failing position
   function automatic logic [4:0] hamming_syn(input logic [15:0] cw);
      return {^cw, ^(cw & MASK_S8), ^(cw & MASK_S4), ^(cw & MASK_S2), ^(cw & MASK_S1)};
   endfunction

   // Extracts d11..d1 from a codeword, skipping the check-bit positions
   function automatic logic [10:0] hamming_data(input logic [15:0] cw);
      return {cw[15:9], cw[7:5], cw[3]};
   endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SECDED decoder: corrects one flipped bit, flags two.
module hamming_secded_dec
   import hamming_pkg::*;
(
   input  logic [15:0] cw_i,
   output logic [10:0] data_o,
   output logic [1:0]  flag_o
);

   logic [4:0]  syn_s;
   logic [15:0] cw_fix_s;

   // Classify the codeword and repair a single error before extracting data
   always_comb begin
      syn_s    = hamming_syn(cw_i);
      cw_fix_s = cw_i;
      flag_o   = FLAG_NONE;
      if (syn_s[4]) begin
         // Odd overall parity: exactly one flip; syndrome 0 means only p0 was hit
         flag_o = FLAG_SINGLE;
         if (syn_s[3:0] != 4'd0) begin
            cw_fix_s[syn_s[3:0]] = ~cw_i[syn_s[3:0]];
         end else begin
            cw_fix_s = cw_i;
         end
      end else if (syn_s[3:0] != 4'd0) begin
         // Even parity with a nonzero syndrome: two flips, leave data as received
         flag_o = FLAG_DOUBLE;
      end else begin
         flag_o = FLAG_NONE;
      end
      data_o = hamming_data(cw_fix_s);
   end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-mapped SECDED decode engine: reads N_MSG codewords from data memory,
// writes back corrected payload plus error flag, and counts corrected/detected errors.
module hamming_dec_engine
   import hamming_pkg::*;
#(
   parameter int SRC_BASE = 30,
   parameter int DST_BASE = 0,
   parameter int N_MSG    = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       done,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic       mem_we,
   output logic [7:0] mem_wr_data,
   output logic [7:0] err1_cnt,
   output logic [7:0] err2_cnt
);

   localparam logic [7:0] SRC8     = 8'(SRC_BASE);
   localparam logic [7:0] DST8     = 8'(DST_BASE);
   localparam logic [6:0] LAST_IDX = 7'(N_MSG - 1);

   state_e     state_q, state_d;
   logic [6:0] idx_q, idx_d;
   logic [7:0] lo_q, lo_d;
   logic [7:0] res_hi_q, res_hi_d;
   logic [1:0] flag_q, flag_d;
   logic [7:0] addr_q, addr_d;
   logic       we_q, we_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] err1_q, err1_d;
   logic [7:0] err2_q, err2_d;
   logic       done_q;

   logic [10:0] dec_data_s;
   logic [1:0]  dec_flag_s;
   logic [6:0]  idx_inc_s;
   logic [7:0]  src_lo_s;
   logic [7:0]  dst_lo_s;

   hamming_secded_dec u_dec (
      .cw_i   ({mem_rd_data, lo_q}),
      .data_o (dec_data_s),
      .flag_o (dec_flag_s)
   );

   assign idx_inc_s = idx_q + 7'd1;
   assign src_lo_s  = SRC8 + {idx_q, 1'b0};
   assign dst_lo_s  = DST8 + {idx_q, 1'b0};

   // Next-state and next-output logic; outputs are precomputed for the state being entered
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      flag_d   = flag_q;
      addr_d   = addr_q;
      we_d     = 1'b0;
      wdata_d  = wdata_q;
      err1_d   = err1_q;
      err2_d   = err2_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RD_LO;
               idx_d   = 7'd0;
               err1_d  = 8'd0;
               err2_d  = 8'd0;
               addr_d  = SRC8;
            end else begin
               state_d = state_q;
            end
         end
         ST_RD_LO: begin
            lo_d    = mem_rd_data;
            addr_d  = src_lo_s + 8'd1;
            state_d = ST_RD_HI;
         end
         ST_RD_HI: begin
            flag_d   = dec_flag_s;
            res_hi_d = {dec_flag_s, 3'b000, dec_data_s[10:8]};
            wdata_d  = dec_data_s[7:0];
            addr_d   = dst_lo_s;
            we_d     = 1'b1;
            state_d  = ST_WR_LO;
         end
         ST_WR_LO: begin
            wdata_d = res_hi_q;
            addr_d  = dst_lo_s + 8'd1;
            we_d    = 1'b1;
            state_d = ST_WR_HI;
         end
         ST_WR_HI: begin
            case (flag_q)
               FLAG_SINGLE: err1_d = err1_q + 8'd1;
               FLAG_DOUBLE: err2_d = err2_q + 8'd1;
               default: begin
                  err1_d = err1_q;
                  err2_d = err2_q;
               end
            endcase
            idx_d = idx_inc_s;
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RD_LO;
               addr_d  = SRC8 + {idx_inc_s, 1'b0};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath, address, counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q    <= 7'd0;
         lo_q     <= 8'd0;
         res_hi_q <= 8'd0;
         flag_q   <= FLAG_NONE;
         addr_q   <= 8'd0;
         we_q     <= 1'b0;
         wdata_q  <= 8'd0;
         err1_q   <= 8'd0;
         err2_q   <= 8'd0;
         done_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         flag_q   <= flag_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         err1_q   <= err1_d;
         err2_q   <= err2_d;
         done_q   <= (state_q == ST_DONE);
      end
   end

   assign done        = done_q;
   assign mem_addr    = addr_q;
   assign mem_wr_data = wdata_q;
   assign err1_cnt    = err1_q;
   assign err2_cnt    = err2_q;
   // Reset kills a write already in flight on the same edge
   assign mem_we      = we_q & ~reset;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Self-checking bench for hamming_dec_engine with a behavioural memory and decoder model.
module tb_hamming_dec_engine;

   localparam int SRC = 30;
   localparam int DST = 0;
   localparam int NM  = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       done;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic       mem_we;
   logic [7:0] mem_wr_data;
   logic [7:0] err1_cnt;
   logic [7:0] err2_cnt;

   logic [7:0]  mem [256];
   logic [15:0] cw_tab [NM];
   int n_chk = 0;
   int n_err = 0;

   hamming_dec_engine #(.SRC_BASE(SRC), .DST_BASE(DST), .N_MSG(NM)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .done        (done),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_we      (mem_we),
      .mem_wr_data (mem_wr_data),
      .err1_cnt    (err1_cnt),
      .err2_cnt    (err2_cnt)
   );

   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] = mem_wr_data;
   end

   typedef struct {
      string       name;
      logic [15:0] cw;
      logic [7:0]  lo;
      logic [7:0]  hi;
      int          e1;
      int          e2;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Build a SECDED codeword from 11 data bits by position arithmetic
   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] cw = 16'h0000;
      int k = 0;
      for (int pos = 1; pos < 16; pos++) begin
         if (!is_pow2(pos)) begin
            cw[pos] = d[k];
            k++;
         end
      end
      for (int p = 1; p < 16; p = p * 2) begin
         logic par = 1'b0;
         for (int pos = 1; pos < 16; pos++) begin
            if ((pos & p) != 0) par ^= cw[pos];
         end
         cw[p] = par;
      end
      cw[0] = ^cw[15:1];
      return cw;
   endfunction

   // Reference decode: syndrome = XOR of indices of set bits; returns {flag, data}
   function automatic logic [12:0] ref_dec(input logic [15:0] cw);
      int s = 0;
      int k = 0;
      logic [15:0] c = cw;
      logic [1:0]  f;
      logic [10:0] d = 11'd0;
      for (int pos = 1; pos < 16; pos++) begin
         if (cw[pos]) s = s ^ pos;
      end
      if (^cw) begin
         f = 2'b01;
         if (s != 0) c[s] = ~c[s];
      end else if (s != 0) begin
         f = 2'b10;
      end else begin
         f = 2'b00;
      end
      for (int pos = 1; pos < 16; pos++) begin
         if (!is_pow2(pos)) begin
            d[k] = c[pos];
            k++;
         end
      end
      return {f, d};
   endfunction

   function automatic logic [7:0] exp_lo(input logic [15:0] cw);
      logic [12:0] r = ref_dec(cw);
      return r[7:0];
   endfunction

   function automatic logic [7:0] exp_hi(input logic [15:0] cw);
      logic [12:0] r = ref_dec(cw);
      return {r[12:11], 3'b000, r[10:8]};
   endfunction

   task automatic load_mem();
      for (int i = 0; i < NM; i++) begin
         mem[SRC + 2*i]     = cw_tab[i][7:0];
         mem[SRC + 2*i + 1] = cw_tab[i][15:8];
         mem[DST + 2*i]     = 8'hEE;
         mem[DST + 2*i + 1] = 8'hEE;
      end
   endtask

   // Pulse start so it is sampled on exactly one rising edge; returns at the following negedge
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_check(input string tag, input int e1, input int e2);
      load_mem();
      do_start();
      repeat (60) @(negedge clk);
      chk({tag, " done_before_61"}, {31'd0, done}, 32'd0);
      @(negedge clk);
      chk({tag, " done_at_61"}, {31'd0, done}, 32'd1);
      for (int i = 0; i < NM; i++) begin
         chk($sformatf("%s lo[%0d]", tag, i), {24'd0, mem[DST + 2*i]}, {24'd0, exp_lo(cw_tab[i])});
         chk($sformatf("%s hi[%0d]", tag, i), {24'd0, mem[DST + 2*i + 1]}, {24'd0, exp_hi(cw_tab[i])});
      end
      chk({tag, " err1"}, {24'd0, err1_cnt}, 32'(e1));
      chk({tag, " err2"}, {24'd0, err2_cnt}, 32'(e2));
   endtask

   // Fill the table with random codewords carrying 0, 1 or 2 injected flips
   task automatic fill_random(output int e1, output int e2);
      e1 = 0;
      e2 = 0;
      for (int i = 0; i < NM; i++) begin
         int nf = $urandom_range(0, 2);
         int b1 = $urandom_range(0, 15);
         int b2 = (b1 + $urandom_range(1, 15)) % 16;
         logic [15:0] cw = encode(11'($urandom));
         if (nf >= 1) cw[b1] = ~cw[b1];
         if (nf == 2) cw[b2] = ~cw[b2];
         if (nf == 1) e1++;
         if (nf == 2) e2++;
         cw_tab[i] = cw;
      end
   endtask

   initial begin
      vec_t vt [4];
      int e1;
      int e2;

      vt[0] = '{"clean",     16'hAA5A, 8'h55, 8'h05, 0, 0};
      vt[1] = '{"flip9",     16'hA85A, 8'h55, 8'h45, 1, 0};
      vt[2] = '{"flip_p0",   16'hAA5B, 8'h55, 8'h45, 1, 0};
      vt[3] = '{"flip9and3", 16'hA852, 8'h44, 8'h85, 0, 1};

      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst done",   {31'd0, done},        32'd0);
      chk("rst we",     {31'd0, mem_we},      32'd0);
      chk("rst addr",   {24'd0, mem_addr},    32'd0);
      chk("rst wdata",  {24'd0, mem_wr_data}, 32'd0);
      chk("rst err1",   {24'd0, err1_cnt},    32'd0);
      chk("rst err2",   {24'd0, err2_cnt},    32'd0);

      // Reset and start together: reset wins, block stays idle
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_start addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_start done", {31'd0, done},     32'd0);

      // Directed codewords in message 0, clean random codewords elsewhere
      for (int v = 0; v < 4; v++) begin
         cw_tab[0] = vt[v].cw;
         for (int i = 1; i < NM; i++) cw_tab[i] = encode(11'($urandom));
         run_check(vt[v].name, vt[v].e1, vt[v].e2);
         chk({vt[v].name, " byte0"}, {24'd0, mem[DST]},     {24'd0, vt[v].lo});
         chk({vt[v].name, " byte1"}, {24'd0, mem[DST + 1]}, {24'd0, vt[v].hi});
      end

      // Randomized full runs against the reference model
      for (int r = 0; r < 4; r++) begin
         fill_random(e1, e2);
         run_check($sformatf("rand%0d", r), e1, e2);
      end

      // Reset during WR_LO of message 3
      fill_random(e1, e2);
      load_mem();
      do_start();
      repeat (14) @(negedge clk);
      chk("abort in_wr_lo we",   {31'd0, mem_we},   32'd1);
      chk("abort in_wr_lo addr", {24'd0, mem_addr}, 32'(DST + 6));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("abort lo[%0d]", i), {24'd0, mem[DST + 2*i]},     {24'd0, exp_lo(cw_tab[i])});
         chk($sformatf("abort hi[%0d]", i), {24'd0, mem[DST + 2*i + 1]}, {24'd0, exp_hi(cw_tab[i])});
      end
      chk("abort msg3 lo", {24'd0, mem[DST + 6]}, 32'h0000_00EE);
      chk("abort msg3 hi", {24'd0, mem[DST + 7]}, 32'h0000_00EE);
      chk("abort done",    {31'd0, done},         32'd0);
      chk("abort err1",    {24'd0, err1_cnt},     32'd0);
      chk("abort err2",    {24'd0, err2_cnt},     32'd0);
      repeat (2) @(negedge clk);
      chk("abort idle addr", {24'd0, mem_addr}, 32'd0);
      run_check("after_abort", e1, e2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
